// File: rtl/flag_cond_unit_if.sv
// rtl/flag_cond_unit_if.sv - execute-stage result/NZVC bus between ALU side and flag/condition unit
interface flag_cond_unit_if #(
    parameter int WIDTH = 16
);
    logic             stall;
    logic             flush;
    logic             ex_valid;
    logic [3:0]       ex_cond;
    logic             ex_set_flags;
    logic             ex_is_branch;
    logic [WIDTH-1:0] alu_out;
    logic             alu_n;
    logic             alu_z;
    logic             alu_v;
    logic             alu_c;
    logic             cond_pass;
    logic [3:0]       flags;
    logic             mem_valid;
    logic [WIDTH-1:0] mem_result;
    logic             branch_taken;

    modport master (
        output stall, flush, ex_valid, ex_cond, ex_set_flags, ex_is_branch,
        output alu_out, alu_n, alu_z, alu_v, alu_c,
        input  cond_pass, flags, mem_valid, mem_result, branch_taken
    );

    modport slave (
        input  stall, flush, ex_valid, ex_cond, ex_set_flags, ex_is_branch,
        input  alu_out, alu_n, alu_z, alu_v, alu_c,
        output cond_pass, flags, mem_valid, mem_result, branch_taken
    );
endinterface

// File: rtl/flag_cond_unit.sv
// rtl/flag_cond_unit.sv - NZVC status register, condition evaluation, commit and branch-shadow squash
module flag_cond_unit #(
    parameter int         WIDTH       = 16,
    parameter int         BR_SHADOW   = 2,
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input logic             clk,
    input logic             rst,
    flag_cond_unit_if.slave bus
);

    typedef enum logic {
        RUN    = 1'b0,
        SHADOW = 1'b1
    } state_t;

    localparam logic [3:0] SHADOW_LEN = 4'(BR_SHADOW);

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       cnt;
    logic [3:0]       cnt_nxt;
    logic [3:0]       flags_q;
    logic             mem_valid_q;
    logic [WIDTH-1:0] mem_result_q;
    logic             branch_taken_q;

    logic adv;
    logic live;
    logic cond_true;
    logic cond_pass;
    logic take_branch;

    logic fn, fz, fc, fv;

    // Flags are read straight from the register: a producer writes them as it leaves E.
    assign fn = flags_q[3];
    assign fz = flags_q[2];
    assign fc = flags_q[1];
    assign fv = flags_q[0];

    always_comb begin
        cond_true = 1'b0;
        case (bus.ex_cond)
            4'h0:    cond_true = fz;
            4'h1:    cond_true = ~fz;
            4'h2:    cond_true = fc;
            4'h3:    cond_true = ~fc;
            4'h4:    cond_true = fn;
            4'h5:    cond_true = ~fn;
            4'h6:    cond_true = fv;
            4'h7:    cond_true = ~fv;
            4'h8:    cond_true = fc & ~fz;
            4'h9:    cond_true = ~fc | fz;
            4'hA:    cond_true = (fn == fv);
            4'hB:    cond_true = (fn != fv);
            4'hC:    cond_true = ~fz & (fn == fv);
            4'hD:    cond_true = fz | (fn != fv);
            4'hE:    cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    assign adv         = ~bus.stall;
    assign live        = bus.ex_valid & ~bus.flush & (state == RUN);
    assign cond_pass   = live & cond_true;
    assign take_branch = cond_pass & bus.ex_is_branch;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (bus.flush) begin
            state_nxt = RUN;
            cnt_nxt   = 4'd0;
        end else begin
            case (state)
                RUN: begin
                    if (take_branch && (BR_SHADOW > 0)) begin
                        state_nxt = SHADOW;
                        cnt_nxt   = SHADOW_LEN;
                    end
                end
                SHADOW: begin
                    // Counts advancing edges, not valid slots, so bubbles also use up the shadow.
                    if (cnt <= 4'd1) begin
                        state_nxt = RUN;
                        cnt_nxt   = 4'd0;
                    end else begin
                        cnt_nxt = cnt - 4'd1;
                    end
                end
                default: begin
                    state_nxt = RUN;
                    cnt_nxt   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= RUN;
            cnt            <= 4'd0;
            flags_q        <= RESET_FLAGS;
            mem_valid_q    <= 1'b0;
            mem_result_q   <= '0;
            branch_taken_q <= 1'b0;
        end else if (adv) begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            mem_valid_q    <= cond_pass;
            branch_taken_q <= take_branch;
            if (cond_pass && bus.ex_set_flags) begin
                flags_q <= {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v};
            end
            if (cond_pass) begin
                mem_result_q <= bus.alu_out;
            end
        end
    end

    assign bus.cond_pass    = cond_pass;
    assign bus.flags        = flags_q;
    assign bus.mem_valid    = mem_valid_q;
    assign bus.mem_result   = mem_result_q;
    assign bus.branch_taken = branch_taken_q;

endmodule

// File: tb/tb_flag_cond_unit.sv
// tb/tb_flag_cond_unit.sv - scoreboard bench for flag_cond_unit against a behavioural model
module tb_flag_cond_unit;

    localparam int         W    = 16;
    localparam int         SHAD = 2;
    localparam logic [3:0] RSTF = 4'b0000;

    typedef struct {
        logic [3:0]   fl;
        logic         mv;
        logic [W-1:0] mr;
        logic         bt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    flag_cond_unit_if #(.WIDTH(W)) bus ();

    flag_cond_unit #(
        .WIDTH      (W),
        .BR_SHADOW  (SHAD),
        .RESET_FLAGS(RSTF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    exp_t sq[$];
    logic cq[$];

    logic [3:0]   m_flags = RSTF;
    logic         m_mv    = 1'b0;
    logic [W-1:0] m_mr    = '0;
    logic         m_bt    = 1'b0;
    int           m_sh    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Codes come in pairs; the odd member of each pair is the negation of the even one.
    function automatic logic holds(input logic [3:0] cd, input logic [3:0] f);
        logic n, z, c, v, base;
        {n, z, c, v} = f;
        case (cd[3:1])
            3'd0:    base = z;
            3'd1:    base = c;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = c && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return cd[0] ? !base : base;
    endfunction

    task automatic cyc(input logic r, input logic s, input logic f, input logic v,
                       input logic [3:0] cd, input logic sf, input logic br,
                       input logic [W-1:0] a, input logic [3:0] nzcv);
        logic pass;
        exp_t e;
        @(negedge clk);
        rst              = r;
        bus.stall        = s;
        bus.flush        = f;
        bus.ex_valid     = v;
        bus.ex_cond      = cd;
        bus.ex_set_flags = sf;
        bus.ex_is_branch = br;
        bus.alu_out      = a;
        {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v} = nzcv;

        pass = v && !f && (m_sh == 0) && holds(cd, m_flags);
        cq.push_back(pass);

        if (r) begin
            m_flags = RSTF; m_mv = 1'b0; m_mr = '0; m_bt = 1'b0; m_sh = 0;
        end else if (!s) begin
            if (pass && sf) m_flags = nzcv;
            m_mv = pass;
            if (pass) m_mr = a;
            m_bt = pass && br;
            if (f)                 m_sh = 0;
            else if (m_sh > 0)     m_sh = m_sh - 1;
            else if (pass && br)   m_sh = SHAD;
        end
        e.fl = m_flags; e.mv = m_mv; e.mr = m_mr; e.bt = m_bt;
        sq.push_back(e);
    endtask

    task automatic run(input logic [3:0] cd, input logic sf, input logic br,
                       input logic [W-1:0] a, input logic [3:0] nzcv);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, cd, sf, br, a, nzcv);
    endtask

    // Combinational decision, sampled well after the inputs settle.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (cq.size() != 0) begin
                logic ec;
                ec = cq.pop_front();
                chk("cond_pass", 32'(bus.cond_pass), 32'(ec));
            end
        end
    end

    // Registered outputs, sampled just after each edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sq.size() != 0) begin
                exp_t e;
                e = sq.pop_front();
                chk("flags",        32'(bus.flags),        32'(e.fl));
                chk("mem_valid",    32'(bus.mem_valid),    32'(e.mv));
                chk("mem_result",   32'(bus.mem_result),   32'(e.mr));
                chk("branch_taken", 32'(bus.branch_taken), 32'(e.bt));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.stall = 1'b0; bus.flush = 1'b0; bus.ex_valid = 1'b0; bus.ex_cond = 4'h0;
        bus.ex_set_flags = 1'b0; bus.ex_is_branch = 1'b0; bus.alu_out = '0;
        bus.alu_n = 1'b0; bus.alu_z = 1'b0; bus.alu_c = 1'b0; bus.alu_v = 1'b0;

        // Reset, Z write through AL, then EQ passes.
        cyc(1, 0, 0, 0, 4'h0, 0, 0, 16'h0, 4'h0);
        run(4'hE, 1, 0, 16'h1111, 4'b0100);
        run(4'h0, 0, 0, 16'h2222, 4'b0000);

        // N=1,V=0: LT passes, GE fails and leaves flags alone.
        run(4'hE, 1, 0, 16'h3333, 4'b1000);
        run(4'hB, 0, 0, 16'h4444, 4'b0000);
        run(4'hA, 1, 0, 16'h5555, 4'b0110);

        // Taken branch, two squashed slots (one a branch), third commits.
        run(4'hE, 0, 1, 16'h6666, 4'b0000);
        run(4'hE, 0, 1, 16'h7777, 4'b0000);
        run(4'hE, 1, 1, 16'h8888, 4'b1111);
        run(4'hE, 0, 0, 16'h9999, 4'b0000);

        // Stall for three cycles in the middle of the shadow.
        run(4'hE, 0, 1, 16'hA000, 4'b0000);
        run(4'hE, 1, 0, 16'hA001, 4'b1111);
        repeat (3) cyc(0, 1, 0, 1, 4'hE, 1, 1, 16'hA002, 4'b1010);
        run(4'hE, 1, 0, 16'hA003, 4'b1111);
        run(4'hE, 0, 0, 16'hA004, 4'b0000);

        // Flush on a taken branch, then flush inside a shadow.
        cyc(0, 0, 1, 1, 4'hE, 1, 1, 16'hB000, 4'b1111);
        run(4'hE, 0, 0, 16'hB001, 4'b0000);
        run(4'hE, 0, 1, 16'hB002, 4'b0000);
        cyc(0, 0, 1, 1, 4'hE, 0, 0, 16'hB003, 4'b0000);
        run(4'hE, 0, 0, 16'hB004, 4'b0000);

        // Flush while stalled has no effect.
        run(4'hE, 0, 1, 16'hB100, 4'b0000);
        cyc(0, 1, 1, 1, 4'hE, 0, 0, 16'hB101, 4'b0000);
        run(4'hE, 0, 0, 16'hB102, 4'b0000);
        run(4'hE, 0, 0, 16'hB103, 4'b0000);
        run(4'hE, 0, 0, 16'hB104, 4'b0000);

        // Reset during a shadow with stall asserted.
        run(4'hE, 1, 1, 16'hC000, 4'b1111);
        cyc(1, 1, 0, 1, 4'hE, 1, 1, 16'hC001, 4'b1111);
        run(4'hE, 0, 0, 16'hC002, 4'b0000);

        // AL and NV across every flag combination, plus the full code table.
        for (int i = 0; i < 16; i++) begin
            run(4'hE, 1, 0, 16'(i), 4'(i));
            run(4'hF, 1, 0, 16'hDEAD, 4'(15 - i));
            run(4'hE, 0, 0, 16'hD000 + 16'(i), 4'h0);
            for (int c = 0; c < 14; c++) run(4'(c), 0, 0, 16'hE000 + 16'(c), 4'h0);
        end

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            cyc(($urandom_range(0, 63) == 0),
                ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 3) != 0),
                4'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0),
                16'($urandom),
                4'($urandom_range(0, 15)));
        end

        repeat (3) @(negedge clk);
        chk("sq_drained", 32'(sq.size()), 32'd0);
        chk("cq_drained", 32'(cq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
